// File: rtl/trackball_ifc.sv
// trackball_ifc: two-axis quadrature trackball counter with atomic snapshot and byte read-back.
// Define TRACKBALL_FILTER_EN to compile in the per-input stable-count glitch filter.
module trackball_ifc #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       qx_a,
  input  logic       qx_b,
  input  logic       qy_a,
  input  logic       qy_b,
  input  logic       flip,
  input  logic       latch_n,
  input  logic       cs_n,
  input  logic       sel,
  output logic [7:0] dout,
  output logic       err
);

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_BAD
  } step_e;

  // Wide enough for the longest guard the filter range allows.
  localparam int unsigned INIT_W = $clog2(FILTER_LEN + 4);
`ifdef TRACKBALL_FILTER_EN
  localparam int unsigned INIT = 3 + FILTER_LEN;
`else
  localparam int unsigned INIT = 3;
`endif
  localparam logic [INIT_W-1:0] INIT_V = INIT_W'(INIT);

  // Bit order everywhere: [0]=qx_a, [1]=qx_b, [2]=qy_a, [3]=qy_b.
  logic [3:0] raw;
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] filt;
  logic [3:0] prev_q;

  assign raw = {qy_b, qy_a, qx_b, qx_a};

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef TRACKBALL_FILTER_EN
  localparam logic [3:0] STAB_LAST = 4'(FILTER_LEN - 1);

  logic [3:0][3:0] stab_q;
  logic [3:0][3:0] stab_d;
  logic [3:0]      filt_q;
  logic [3:0]      filt_d;

  always_comb begin
    filt_d = filt_q;
    stab_d = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (stab_q[i] == STAB_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      stab_q <= '0;
      filt_q <= '0;
    end else begin
      stab_q <= stab_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync2_q;
`endif

  logic [INIT_W-1:0] init_q;
  logic [INIT_W-1:0] init_d;
  logic              run;

  assign run    = (init_q == INIT_V);
  assign init_d = run ? init_q : init_q + INIT_W'(1);

  function automatic logic [1:0] phase(input logic [1:0] ab);
    unique case (ab)
      2'b00:   phase = 2'd0;
      2'b01:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  function automatic step_e decode(input logic [1:0] prev_ab,
                                   input logic [1:0] cur_ab,
                                   input logic       rev);
    logic [1:0] d;
    d = phase(cur_ab) - phase(prev_ab);
    unique case (d)
      2'd1:    decode = rev ? STEP_DN : STEP_UP;
      2'd3:    decode = rev ? STEP_UP : STEP_DN;
      2'd2:    decode = STEP_BAD;
      default: decode = STEP_NONE;
    endcase
  endfunction

  function automatic logic [7:0] bump(input logic [7:0] cnt, input step_e s);
    unique case (s)
      STEP_UP: bump = cnt + 8'd1;
      STEP_DN: bump = cnt - 8'd1;
      default: bump = cnt;
    endcase
  endfunction

  step_e step_x;
  step_e step_y;

  always_comb begin
    step_x = STEP_NONE;
    step_y = STEP_NONE;
    if (run) begin
      step_x = decode({prev_q[0], prev_q[1]}, {filt[0], filt[1]}, flip);
      step_y = decode({prev_q[2], prev_q[3]}, {filt[2], filt[3]}, flip);
    end
  end

  logic [7:0] cnt_x_q,  cnt_x_d;
  logic [7:0] cnt_y_q,  cnt_y_d;
  logic [7:0] hold_x_q, hold_x_d;
  logic [7:0] hold_y_q, hold_y_d;
  logic [7:0] dout_q,   dout_d;
  logic       err_q,    err_d;
  logic       latch_prev_q;
  logic       latch_fall;

  // Holds capture the counters before this cycle's step, so a snapshot is never torn.
  always_comb begin
    latch_fall = !latch_n && latch_prev_q;
    cnt_x_d    = bump(cnt_x_q, step_x);
    cnt_y_d    = bump(cnt_y_q, step_y);
    hold_x_d   = latch_fall ? cnt_x_q : hold_x_q;
    hold_y_d   = latch_fall ? cnt_y_q : hold_y_q;
    err_d      = err_q;
    if (latch_fall) begin
      err_d = 1'b0;
    end
    if (step_x == STEP_BAD || step_y == STEP_BAD) begin
      err_d = 1'b1;
    end
    dout_d = cs_n ? dout_q : (sel ? hold_y_q : hold_x_q);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      init_q       <= '0;
      prev_q       <= '0;
      cnt_x_q      <= '0;
      cnt_y_q      <= '0;
      hold_x_q     <= '0;
      hold_y_q     <= '0;
      dout_q       <= '0;
      err_q        <= 1'b0;
      latch_prev_q <= 1'b0;
    end else begin
      init_q       <= init_d;
      prev_q       <= filt;
      cnt_x_q      <= cnt_x_d;
      cnt_y_q      <= cnt_y_d;
      hold_x_q     <= hold_x_d;
      hold_y_q     <= hold_y_d;
      dout_q       <= dout_d;
      err_q        <= err_d;
      latch_prev_q <= latch_n;
    end
  end

  assign dout = dout_q;
  assign err  = err_q;

endmodule

// File: tb/tb_trackball_ifc.sv
// Self-checking bench for trackball_ifc: step-sequence table, snapshot/latency corner cases,
// and randomized movement against a position/count model.
module tb_trackball_ifc;

  localparam int unsigned FL = 3;
`ifdef TRACKBALL_FILTER_EN
  localparam int unsigned LAT = 2 + FL;
`else
  localparam int unsigned LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       clr_n;
  logic       qx_a, qx_b, qy_a, qy_b;
  logic       flip;
  logic       latch_n;
  logic       cs_n;
  logic       sel;
  logic [7:0] dout;
  logic       err;

  always #5 clk = ~clk;

  trackball_ifc #(.FILTER_LEN(FL)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .qx_a    (qx_a),
    .qx_b    (qx_b),
    .qy_a    (qy_a),
    .qy_b    (qy_b),
    .flip    (flip),
    .latch_n (latch_n),
    .cs_n    (cs_n),
    .sel     (sel),
    .dout    (dout),
    .err     (err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [1:0]  gray_tab [4];
  int unsigned xpos, ypos;
  logic [7:0]  mx, my, hx, hy;
  logic        merr;

  typedef struct {
    logic        axis;
    int unsigned n;
    logic        up;
    logic        flp;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [7];

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive_q();
    {qx_a, qx_b} = gray_tab[xpos];
    {qy_a, qy_b} = gray_tab[ypos];
  endtask

  // Physical movement one phase along the quadrature cycle; model counts it immediately.
  task automatic step(input logic axis, input logic up, input int unsigned gap);
    logic plus;
    plus = up ^ flip;
    if (!axis) begin
      xpos = (xpos + (up ? 1 : 3)) % 4;
      mx   = plus ? mx + 8'd1 : mx - 8'd1;
    end else begin
      ypos = (ypos + (up ? 1 : 3)) % 4;
      my   = plus ? my + 8'd1 : my - 8'd1;
    end
    drive_q();
    tick(gap);
  endtask

  task automatic illegal(input logic axis, input int unsigned gap);
    if (!axis) xpos = (xpos + 2) % 4;
    else       ypos = (ypos + 2) % 4;
    merr = 1'b1;
    drive_q();
    tick(gap);
  endtask

  task automatic do_latch();
    latch_n = 1'b0;
    tick(1);
    latch_n = 1'b1;
    hx   = mx;
    hy   = my;
    merr = 1'b0;
  endtask

  task automatic do_read(input logic s, input string name, input logic [7:0] exp);
    cs_n = 1'b0;
    sel  = s;
    tick(1);
    cs_n = 1'b1;
    check(name, dout, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    logic [7:0] pre;
    gray_tab[0] = 2'b00;
    gray_tab[1] = 2'b01;
    gray_tab[2] = 2'b11;
    gray_tab[3] = 2'b10;

    vt[0] = '{axis: 1'b0, n: 16, up: 1'b1, flp: 1'b0, exp: 8'h10};
    vt[1] = '{axis: 1'b0, n: 16, up: 1'b1, flp: 1'b1, exp: 8'h00};
    vt[2] = '{axis: 1'b1, n: 1,  up: 1'b0, flp: 1'b0, exp: 8'hFF};
    vt[3] = '{axis: 1'b1, n: 1,  up: 1'b1, flp: 1'b0, exp: 8'h00};
    vt[4] = '{axis: 1'b0, n: 3,  up: 1'b0, flp: 1'b0, exp: 8'hFD};
    vt[5] = '{axis: 1'b1, n: 5,  up: 1'b0, flp: 1'b1, exp: 8'h05};
    vt[6] = '{axis: 1'b0, n: 7,  up: 1'b1, flp: 1'b1, exp: 8'hF6};

    // Reset with static non-zero inputs: x at 11, y at 10.
    clr_n = 1'b0; flip = 1'b0; latch_n = 1'b1; cs_n = 1'b1; sel = 1'b0;
    xpos = 2; ypos = 3; drive_q();
    mx = '0; my = '0; hx = '0; hy = '0; merr = 1'b0;
    tick(3);
    check("reset_dout", dout, 8'h00);
    check("reset_err", {7'b0, err}, 8'h00);
    clr_n = 1'b1;
    tick(20);
    check("idle_err", {7'b0, err}, 8'h00);
    check("idle_dout", dout, 8'h00);
    do_latch();
    do_read(1'b0, "idle_x", 8'h00);
    do_read(1'b1, "idle_y", 8'h00);

    // Table of movement sequences; expected counts are cumulative.
    for (int i = 0; i < 7; i++) begin
      flip = vt[i].flp;
      tick(2);
      for (int unsigned k = 0; k < vt[i].n; k++) step(vt[i].axis, vt[i].up, 8);
      do_latch();
      do_read(vt[i].axis, $sformatf("table%0d", i), vt[i].exp);
      check($sformatf("table%0d_err", i), {7'b0, err}, 8'h00);
    end
    flip = 1'b0;
    tick(2);

    // Illegal 00 -> 11 on X: err appears on the edge the step would have counted.
    while (xpos != 0) step(1'b0, 1'b1, 8);
    illegal(1'b0, LAT);
    check("illegal_err_early", {7'b0, err}, 8'h00);
    tick(1);
    check("illegal_err_set", {7'b0, err}, 8'h01);
    tick(6);
    check("illegal_err_sticky", {7'b0, err}, 8'h01);
    do_latch();
    check("illegal_err_clear", {7'b0, err}, 8'h00);
    do_read(1'b0, "illegal_count", mx);

    // Latch on the same edge as the step: snapshot gets the pre-step value.
    pre = mx;
    step(1'b0, 1'b1, LAT);
    latch_n = 1'b0;
    tick(1);
    latch_n = 1'b1;
    hx = pre;
    do_read(1'b0, "snap_pre", pre);
    do_latch();
    do_read(1'b0, "snap_post", mx);

    // One edge later the step is already in the snapshot.
    step(1'b0, 1'b1, LAT + 1);
    do_latch();
    do_read(1'b0, "latency_post", mx);

    // latch_n held low for 10 clocks takes exactly one snapshot.
    latch_n = 1'b0;
    tick(1);
    pre = mx;
    step(1'b0, 1'b1, 9);
    latch_n = 1'b1;
    tick(1);
    do_read(1'b0, "long_latch_single", pre);
    do_latch();
    check("dout_hold", dout, pre);
    do_read(1'b0, "long_latch_post", mx);

    // Latch and read in the same cycle: read sees the old hold value.
    pre = hx;
    step(1'b0, 1'b0, 8);
    latch_n = 1'b0;
    cs_n = 1'b0;
    sel = 1'b0;
    tick(1);
    latch_n = 1'b1;
    cs_n = 1'b1;
    check("latch_read_same", dout, pre);
    hx = mx;
    do_read(1'b0, "latch_read_next", mx);

`ifdef TRACKBALL_FILTER_EN
    // Two-clock glitch on qx_a is rejected.
    qx_a = ~qx_a;
    tick(2);
    qx_a = ~qx_a;
    tick(12);
    check("glitch_err", {7'b0, err}, 8'h00);
    do_latch();
    do_read(1'b0, "glitch_count", mx);
`endif

    // Asynchronous reset in the middle of activity.
    illegal(1'b1, 8);
    check("pre_reset_err", {7'b0, err}, 8'h01);
    #3 clr_n = 1'b0;
    #1;
    check("async_reset_err", {7'b0, err}, 8'h00);
    check("async_reset_dout", dout, 8'h00);
    @(negedge clk);
    clr_n = 1'b1;
    mx = '0; my = '0; hx = '0; hy = '0; merr = 1'b0;
    tick(20);
    check("rereset_err", {7'b0, err}, 8'h00);
    do_latch();
    do_read(1'b0, "rereset_x", 8'h00);
    do_read(1'b1, "rereset_y", 8'h00);

    // Randomized movement against the model.
    for (int k = 0; k < 300; k++) begin
      logic        ax;
      int unsigned gap;
      ax  = 1'($urandom_range(0, 1));
      gap = $urandom_range(LAT + 1, LAT + 4);
      if ($urandom_range(0, 15) == 0) begin
        illegal(ax, gap);
      end else begin
        flip = 1'($urandom_range(0, 1));
        step(ax, 1'($urandom_range(0, 1)), gap);
      end
      if (k % 10 == 9) begin
        check($sformatf("rnd%0d_err", k), {7'b0, err}, {7'b0, merr});
        do_latch();
        check($sformatf("rnd%0d_err_clr", k), {7'b0, err}, 8'h00);
        do_read(1'b0, $sformatf("rnd%0d_x", k), mx);
        do_read(1'b1, $sformatf("rnd%0d_y", k), my);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
